// File: rtl/win_buff_pkg.sv
// Shared defaults, pixel type and column-wrap helper for the sliding pixel window.
package win_buff_pkg;

   localparam int DW_DEF    = 8;
   localparam int CH_DEF    = 3;
   localparam int K_DEF     = 3;
   localparam int IMG_W_DEF = 32;
   localparam int PW_DEF    = DW_DEF * CH_DEF;

   typedef logic [PW_DEF-1:0] pixel_t;

   function automatic int unsigned wrap_inc(input int unsigned c, input int unsigned n);
      return (c >= n - 1) ? 0 : c + 1;
   endfunction

endpackage

// File: rtl/win_col_ctr.sv
// Row column counter: tracks the column of the next pixel and decides whether
// an accepted pixel completes a presentable window.
module win_col_ctr
   import win_buff_pkg::*;
#(
   parameter int K     = K_DEF,
   parameter int IMG_W = IMG_W_DEF,
   parameter int PAD   = 0,
   parameter int CW    = $clog2(IMG_W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          accept,
   input  logic          out_ready,
   output logic          row_start,
   output logic          out_valid,
   output logic [CW-1:0] out_col
);

   localparam logic [CW-1:0] FIRST_WIN = CW'(K - 1);

   logic [CW-1:0] col_p0;
   logic          win_ok;

   assign row_start = (col_p0 == '0);
   assign win_ok    = (PAD != 0) || (col_p0 >= FIRST_WIN);

   // p0 -> p1: accepted column becomes the presented column
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_p0    <= '0;
         out_col   <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         col_p0    <= '0;
         out_col   <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         col_p0    <= CW'(wrap_inc(32'(col_p0), unsigned'(IMG_W)));
         out_col   <= col_p0;
         out_valid <= win_ok;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/win_buff.sv
// K-tap sliding window over a pixel row with valid/ready handshakes on both sides.
// Taps are zero-filled at each row start so a window never straddles two rows.
module win_buff
   import win_buff_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int CH    = CH_DEF,
   parameter int K     = K_DEF,
   parameter int IMG_W = IMG_W_DEF,
   parameter int PAD   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH*DW-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [K*CH*DW-1:0]       out_data,
   output logic [$clog2(IMG_W)-1:0] out_col
);

   localparam int PW = CH * DW;
   localparam int CW = $clog2(IMG_W);

   logic [PW-1:0] tap_p0 [K];
   logic          accept;
   logic          row_start;

   assign in_ready = (!out_valid || out_ready) && !clear;
   assign accept   = in_valid && in_ready;

   win_col_ctr #(
      .K     (K),
      .IMG_W (IMG_W),
      .PAD   (PAD),
      .CW    (CW)
   ) u_col (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .accept    (accept),
      .out_ready (out_ready),
      .row_start (row_start),
      .out_valid (out_valid),
      .out_col   (out_col)
   );

   // p0: tap chain, doubles as the output window register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < K; i++) tap_p0[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < K; i++) tap_p0[i] <= '0;
      end else if (accept) begin
         tap_p0[0] <= in_data;
         for (int i = 1; i < K; i++) tap_p0[i] <= row_start ? '0 : tap_p0[i-1];
      end
   end

   // Newest tap lands in the most significant slice
   always_comb begin
      out_data = '0;
      for (int i = 0; i < K; i++) out_data[(K-1-i)*PW +: PW] = tap_p0[i];
   end

endmodule

// File: tb/tb_win_buff.sv
// Scoreboard bench: a PAD=0 and a PAD=1 instance, each with its own window model and queue.
module tb_win_buff;
   import win_buff_pkg::*;

   localparam int K     = 3;
   localparam int IMG_W = 8;
   localparam int PW    = 24;
   localparam int WW    = K * PW;

   typedef struct packed {
      logic [WW-1:0] d;
      logic [2:0]    c;
   } win_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          in_valid_a  [2];
   pixel_t        in_data_a   [2];
   logic          out_ready_a [2];
   logic          in_ready_a  [2];
   logic          out_valid_a [2];
   logic [WW-1:0] out_data_a  [2];
   logic [2:0]    out_col_a   [2];

   int     n_cmp = 0;
   int     n_bad = 0;
   win_t   q0[$];
   win_t   q1[$];
   pixel_t mtap [2][K];
   int     mcol [2];
   int     nwin [2];

   always #5 clk = ~clk;

   win_buff #(.DW(8), .CH(3), .K(K), .IMG_W(IMG_W), .PAD(0)) u_pad0 (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid_a[0]),
      .in_ready  (in_ready_a[0]),
      .in_data   (in_data_a[0]),
      .out_valid (out_valid_a[0]),
      .out_ready (out_ready_a[0]),
      .out_data  (out_data_a[0]),
      .out_col   (out_col_a[0])
   );

   win_buff #(.DW(8), .CH(3), .K(K), .IMG_W(IMG_W), .PAD(1)) u_pad1 (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid_a[1]),
      .in_ready  (in_ready_a[1]),
      .in_data   (in_data_a[1]),
      .out_valid (out_valid_a[1]),
      .out_ready (out_ready_a[1]),
      .out_data  (out_data_a[1]),
      .out_col   (out_col_a[1])
   );

   function automatic pixel_t pix(input int n);
      return pixel_t'(32'h010101 * n);
   endfunction

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_win(input string tag, input int d, input logic [WW-1:0] exp_d, input int exp_c);
      chk({tag, "_vld"},  80'(out_valid_a[d]), 80'(1));
      chk({tag, "_data"}, 80'(out_data_a[d]),  80'(exp_d));
      chk({tag, "_col"},  80'(out_col_a[d]),   80'(exp_c));
   endtask

   task automatic model_reset(input int d);
      for (int i = 0; i < K; i++) mtap[d][i] = '0;
      mcol[d] = 0;
      if (d == 0) q0.delete();
      else        q1.delete();
   endtask

   // Sampled at the falling edge: predicts what the next rising edge will do
   task automatic mon(input int d, input bit pad);
      win_t w;
      int   qs;
      qs = (d == 0) ? q0.size() : q1.size();
      chk((d == 0) ? "pad0_in_ready" : "pad1_in_ready", 80'(in_ready_a[d]),
          80'((!out_valid_a[d] || out_ready_a[d]) && !clear));
      chk((d == 0) ? "pad0_out_valid" : "pad1_out_valid", 80'(out_valid_a[d]), 80'(qs != 0));
      if (out_valid_a[d] && out_ready_a[d] && qs != 0) begin
         if (d == 0) w = q0.pop_front();
         else        w = q1.pop_front();
         chk((d == 0) ? "pad0_sb_data" : "pad1_sb_data", 80'(out_data_a[d]), 80'(w.d));
         chk((d == 0) ? "pad0_sb_col" : "pad1_sb_col", 80'(out_col_a[d]), 80'(w.c));
         nwin[d]++;
      end
      if (clear) begin
         model_reset(d);
      end else if (in_valid_a[d] && in_ready_a[d]) begin
         for (int i = K - 1; i > 0; i--) mtap[d][i] = (mcol[d] == 0) ? '0 : mtap[d][i-1];
         mtap[d][0] = in_data_a[d];
         w.d = {mtap[d][0], mtap[d][1], mtap[d][2]};
         w.c = 3'(mcol[d]);
         if (pad || mcol[d] >= K - 1) begin
            if (d == 0) q0.push_back(w);
            else        q1.push_back(w);
         end
         mcol[d] = (mcol[d] == IMG_W - 1) ? 0 : mcol[d] + 1;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         mon(0, 1'b0);
         mon(1, 1'b1);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input int n);
      int t;
      t = 0;
      in_valid_a[d] = 1'b1;
      in_data_a[d]  = pix(n);
      @(negedge clk);
      while (!in_ready_a[d] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready_a[d]) chk("send_timeout_in_ready", 80'(in_ready_a[d]), 80'(1));
      @(posedge clk);
      #1;
      in_valid_a[d] = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid_a[d]  = 1'b0;
         in_data_a[d]   = '0;
         out_ready_a[d] = 1'b1;
         nwin[d]        = 0;
      end
      for (int d = 0; d < 2; d++) model_reset(d);
      #2 rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_out_valid", 80'(out_valid_a[d]), 80'(0));
         chk("rst_out_data",  80'(out_data_a[d]),  80'(0));
         chk("rst_out_col",   80'(out_col_a[d]),   80'(0));
         chk("rst_in_ready",  80'(in_ready_a[d]),  80'(1));
      end
      idle(2);
      rst = 1'b1;
      idle(1);

      // PAD=0 first row
      for (int n = 0; n < 8; n++) begin
         send(0, n);
         if (n < 2)  chk("pad0_warmup_vld", 80'(out_valid_a[0]), 80'(0));
         if (n == 2) chk_win("pad0_first", 0, {pix(2), pix(1), pix(0)}, 2);
         if (n == 7) chk_win("pad0_last", 0, {pix(7), pix(6), pix(5)}, 7);
      end
      idle(2);
      chk("pad0_row_windows", 80'(nwin[0]), 80'(6));

      // Row wrap
      send(0, 8);
      chk("wrap_p8_vld", 80'(out_valid_a[0]), 80'(0));
      send(0, 9);
      chk("wrap_p9_vld", 80'(out_valid_a[0]), 80'(0));
      send(0, 10);
      chk_win("wrap_p10", 0, {pix(10), pix(9), pix(8)}, 2);
      for (int n = 11; n < 16; n++) send(0, n);

      // Backpressure
      for (int n = 16; n < 19; n++) send(0, n);
      out_ready_a[0] = 1'b0;
      in_valid_a[0]  = 1'b1;
      in_data_a[0]   = pix(19);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", 80'(in_ready_a[0]), 80'(0));
         chk_win("bp_hold", 0, {pix(18), pix(17), pix(16)}, 2);
      end
      out_ready_a[0] = 1'b1;
      for (int n = 19; n < 24; n++) begin
         send(0, n);
         if (n == 19) chk_win("bp_resume", 0, {pix(19), pix(18), pix(17)}, 3);
      end
      idle(2);
      chk("bp_total_windows", 80'(nwin[0]), 80'(18));

      // Mid-row reset
      for (int n = 24; n < 28; n++) send(0, n);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 80'(out_valid_a[0]), 80'(0));
      chk("mid_rst_out_data",  80'(out_data_a[0]),  80'(0));
      chk("mid_rst_out_col",   80'(out_col_a[0]),   80'(0));
      chk("mid_rst_in_ready",  80'(in_ready_a[0]),  80'(1));
      idle(2);
      rst = 1'b1;
      send(0, 28);
      chk("post_rst_p28_vld", 80'(out_valid_a[0]), 80'(0));
      send(0, 29);
      send(0, 30);
      chk_win("post_rst_first", 0, {pix(30), pix(29), pix(28)}, 2);
      idle(2);

      // PAD=1 row
      for (int n = 0; n < 8; n++) begin
         send(1, n);
         if (n == 0) chk_win("pad1_p0", 1, {pix(0), 24'h0, 24'h0}, 0);
         if (n == 1) chk_win("pad1_p1", 1, {pix(1), pix(0), 24'h0}, 1);
         if (n == 2) chk_win("pad1_p2", 1, {pix(2), pix(1), pix(0)}, 2);
      end
      idle(2);
      chk("pad1_row_windows", 80'(nwin[1]), 80'(8));

      // Clear mid-row drops the concurrent pixel
      for (int n = 8; n < 11; n++) send(1, n);
      clear         = 1'b1;
      in_valid_a[1] = 1'b1;
      in_data_a[1]  = pix(11);
      @(negedge clk);
      chk("clr_in_ready", 80'(in_ready_a[1]), 80'(0));
      @(posedge clk);
      #1;
      clear         = 1'b0;
      in_valid_a[1] = 1'b0;
      chk("clr_out_valid", 80'(out_valid_a[1]), 80'(0));
      send(1, 12);
      chk_win("clr_next_col0", 1, {pix(12), 24'h0, 24'h0}, 0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/win_buff.md
WIN_BUFF -- requirements
Module: win_buff

Interface
REQ-001 Parameter DW, default 8: bits per channel sample.
REQ-002 Parameter CH, default 3: channels per pixel; pixel width PW = CH*DW.
REQ-003 Parameter K, default 3: window depth in pixels (taps), K >= 2.
REQ-004 Parameter IMG_W, default 32: pixels per image row, IMG_W >= K.
REQ-005 Parameter PAD, default 0: 0 = valid windows only; 1 = zero-padded windows from column 0.
REQ-006 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 clear  in  1  synchronous flush, active-high.
REQ-009 in_valid  in  1  in_data carries a pixel.
REQ-010 in_ready  out  1  block can accept a pixel this cycle.
REQ-011 in_data  in  PW  pixel, channel 0 in the LSBs.
REQ-012 out_valid  out  1  out_data holds a window.
REQ-013 out_ready  in  1  consumer takes the window this cycle.
REQ-014 out_data  out  K*PW  window; newest pixel (tap 0) in the MSB slice, oldest (tap K-1) in the LSB slice.
REQ-015 out_col  out  $clog2(IMG_W)  row column of the tap-0 pixel in the presented window.

Function
REQ-016 The block SHALL accept a pixel when in_valid && in_ready.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !clear.
REQ-018 On accept, tap i SHALL load tap i-1 for i = 1..K-1, and tap 0 SHALL load in_data.
REQ-019 On accept at column 0, taps 1..K-1 SHALL load zero so no window spans two rows.
REQ-020 On accept, the column counter SHALL increment, wrapping from IMG_W-1 to 0.
REQ-021 On accept, out_valid SHALL be set the next cycle if PAD=1 or if the accepted column >= K-1; otherwise it SHALL be cleared.
REQ-022 On accept, out_data SHALL present the shifted taps and out_col the accepted column, with 1-cycle latency.
REQ-023 With no accept and out_ready high, out_valid SHALL clear next cycle.
REQ-024 With out_valid high and out_ready low, out_data, out_col and all taps SHALL hold.
REQ-025 Accept and consume in the same cycle SHALL sustain one window per clock with no bubble.
REQ-026 PAD=0 SHALL emit IMG_W-K+1 windows per row; PAD=1 SHALL emit IMG_W windows per row.
REQ-027 clear SHALL take priority over accept: taps, column counter and out_valid SHALL go to zero, and the concurrent pixel SHALL be dropped.

Reset
REQ-028 While rst is low, all taps, the column counter, out_valid, out_data and out_col SHALL be zero.
REQ-029 Consequently in_ready SHALL be 1 during and after reset when clear is low.
REQ-030 Assertion of rst mid-row SHALL discard partial windows; the first pixel after release SHALL be column 0.

Structure
REQ-031 Package win_buff_pkg SHALL hold the default DW, CH, K and IMG_W constants and the pixel_t typedef (PW bits).
REQ-032 Sub-module win_col_ctr SHALL hold the column counter, wrap logic and the window-valid decision.
REQ-033 The tap chain and output register SHALL be implemented in win_buff.

Verification
Scenarios use DW=8, CH=3, K=3, IMG_W=8 and pixel pn = 0x010101*n.
REQ-034 Reset: assert rst mid-stream -> out_valid=0, out_data=0, in_ready=1; the next pixel is taken as column 0.
REQ-035 PAD=0 stream: p0..p7 back-to-back with out_ready=1 -> first out_valid the cycle after p2 is accepted with out_data={p2,p1,p0}, out_col=2; 6 windows total, last is {p7,p6,p5} at out_col=7.
REQ-036 Row wrap: after p7, send p8, p9 -> no out_valid; p10 -> {p10,p9,p8} at out_col=2, with no p7 content.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable; after release, windows resume in order with no pixel lost or duplicated.
REQ-038 PAD=1: p0 -> out_valid with {p0,0,0} at out_col=0; p1 -> {p1,p0,0}; p2 -> {p2,p1,p0}; 8 windows per row.
REQ-039 Clear: assert clear with in_valid=1 mid-row -> pixel dropped, out_valid=0 next cycle; the next accepted pixel is column 0.
